// File: rtl/cfg_reg_arb.sv
// cfg_reg_arb: round-robin arbiter/sequencer between two config masters and a cfg_reg bank.
// Optional write lock per register is enabled by defining CFG_REG_LOCK_EN.
module cfg_reg_arb #(
    parameter int                        REG_NUM        = 8,
    parameter int                        REG_ADDR_WIDTH = 32,
    parameter int                        REG_DATA_WIDTH = 32,
    parameter logic [REG_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                        ADDR_STRIDE    = 4
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              m0_req,
    input  logic                              m0_wr,
    input  logic [REG_ADDR_WIDTH-1:0]         m0_addr,
    input  logic [REG_DATA_WIDTH-1:0]         m0_wdata,
    output logic                              m0_ack,
    output logic [REG_DATA_WIDTH-1:0]         m0_rdata,
    output logic                              m0_err,
    input  logic                              m1_req,
    input  logic                              m1_wr,
    input  logic [REG_ADDR_WIDTH-1:0]         m1_addr,
    input  logic [REG_DATA_WIDTH-1:0]         m1_wdata,
    output logic                              m1_ack,
    output logic [REG_DATA_WIDTH-1:0]         m1_rdata,
    output logic                              m1_err,
    output logic [REG_NUM-1:0]                cfg_vld,
    output logic [REG_DATA_WIDTH-1:0]         cfg_data,
`ifdef CFG_REG_LOCK_EN
    input  logic [REG_NUM-1:0]                cfg_lock,
`endif
    input  logic [REG_NUM*REG_DATA_WIDTH-1:0] reg_data_bus
);

    localparam int AW = REG_ADDR_WIDTH;
    localparam int DW = REG_DATA_WIDTH;
    localparam int IW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam int SH = $clog2(ADDR_STRIDE);
    localparam logic [AW-1:0] STRIDE_MASK = AW'(ADDR_STRIDE - 1);
    localparam logic [AW-1:0] REG_LIMIT   = AW'(REG_NUM);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state_q, state_d;
    logic            rr;
    logic            any_req, sel_m1, sel_wr, sel_hit, wr_blk;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic [IW-1:0]   sel_idx;
    logic            gnt_m1, lat_wr, lat_hit, lat_err;
    logic [IW-1:0]   lat_idx;
    logic [DW-1:0]   rd_word;

    function automatic logic addr_hit(input logic [AW-1:0] addr);
        logic [AW-1:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && ((off & STRIDE_MASK) == '0) && ((off >> SH) < REG_LIMIT);
    endfunction

    function automatic logic [IW-1:0] addr_idx(input logic [AW-1:0] addr);
        logic [AW-1:0] off;
        off = addr - BASE_ADDR;
        return IW'(off >> SH);
    endfunction

    // Decode runs on the granting edge so the strobe can be registered straight into EXEC.
    always_comb begin
        any_req   = m0_req | m1_req;
        sel_m1    = (m0_req && m1_req) ? rr : m1_req;
        sel_wr    = sel_m1 ? m1_wr : m0_wr;
        sel_addr  = sel_m1 ? m1_addr : m0_addr;
        sel_wdata = sel_m1 ? m1_wdata : m0_wdata;
        sel_hit   = addr_hit(sel_addr);
        sel_idx   = addr_idx(sel_addr);
`ifdef CFG_REG_LOCK_EN
        wr_blk    = cfg_lock[sel_idx];
`else
        wr_blk    = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // IDLE -> EXEC: capture the granted transaction context
    always_ff @(posedge clk) begin
        if (state_q == IDLE && any_req) begin
            gnt_m1  <= sel_m1;
            lat_wr  <= sel_wr;
            lat_hit <= sel_hit;
            lat_idx <= sel_idx;
            lat_err <= !sel_hit || (sel_wr && wr_blk);
        end
    end

    always_comb begin
        rd_word = '0;
        if (!lat_wr && lat_hit) rd_word = reg_data_bus[lat_idx*DW +: DW];
    end

    // EXEC -> RESP: readback captured and response driven to the granted master only
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr       <= 1'b0;
            cfg_vld  <= '0;
            cfg_data <= '0;
            m0_ack   <= 1'b0;
            m0_rdata <= '0;
            m0_err   <= 1'b0;
            m1_ack   <= 1'b0;
            m1_rdata <= '0;
            m1_err   <= 1'b0;
        end else begin
            cfg_vld  <= '0;
            m0_ack   <= 1'b0;
            m0_rdata <= '0;
            m0_err   <= 1'b0;
            m1_ack   <= 1'b0;
            m1_rdata <= '0;
            m1_err   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req && sel_wr && sel_hit && !wr_blk) begin
                        cfg_vld  <= REG_NUM'(1) << sel_idx;
                        cfg_data <= sel_wdata;
                    end
                end
                EXEC: begin
                    m0_ack   <= !gnt_m1;
                    m0_err   <= !gnt_m1 && lat_err;
                    m0_rdata <= gnt_m1 ? '0 : rd_word;
                    m1_ack   <= gnt_m1;
                    m1_err   <= gnt_m1 && lat_err;
                    m1_rdata <= gnt_m1 ? rd_word : '0;
                end
                RESP:    rr <= !gnt_m1;
                default: ;
            endcase
        end
    end

endmodule
